ram_sync_clr: RTL and testbench
===============================

# ram_sync_clr

Parametrised single-port synchronous RAM: next generation of the 64×16 gate-level RAM. Generalises word width and depth, replaces the tri-stated read output with a registered output plus a valid strobe, and adds an asynchronous reset with a hardware clear sequencer that initialises every word. A synchronous `clr` request re-runs that sequencer at any time. Used as general register-file and scratch storage by datapath blocks that need known memory contents after reset.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `AW`, 6, address width; depth DEPTH = 2^AW words (AW ≥ 1)
- `INIT_VALUE`, 0, WIDTH-bit value written to every word by the clear sequencer

- `clk` input 1: single clock; all state changes on the rising edge
- `rst` input 1: asynchronous, active-high reset
- `en` input 1: chip enable; gates `w` and `r`
- `w` input 1: write request (effective only when `en`=1)
- `r` input 1: read request (effective only when `en`=1)
- `add` input AW: word address
- `d_in` input WIDTH: write data
- `clr` input 1: synchronous request to re-initialise the whole array to INIT_VALUE
- `d_out` output WIDTH: registered read data; holds the last read value
- `rd_valid` output 1: one-cycle strobe, high the cycle after an accepted read
- `busy` output 1: high while the clear sequencer runs; requests are ignored

## Operation
- States: CLEAR, IDLE. Clear pointer `cp` is AW bits.
- Reset (`rst`=1, asynchronous): state=CLEAR, `cp`=0, `busy`=1, `d_out`=0, `rd_valid`=0. Array contents are not touched by reset itself.
- CLEAR, each edge: mem[`cp`] ← INIT_VALUE, then `cp` ← `cp`+1. On the edge that writes address DEPTH−1: state→IDLE, `busy`→0, `cp` wraps to 0.
- CLEAR with `clr`=1: `cp` restarts at 0 on that edge; address 0 is written on that edge; the full DEPTH-cycle sequence restarts.
- CLEAR: `w`, `r`, `en` are ignored. No array write from `d_in`. `rd_valid`=0. `d_out` holds its value.
- IDLE with `clr`=1: state→CLEAR, `cp`→0, `busy`→1 on that edge. Any `w`/`r` in the same cycle is dropped; `rd_valid`=0 next cycle.
- IDLE, `clr`=0, `en`=1, `w`=1: mem[`add`] ← `d_in`.
- IDLE, `clr`=0, `en`=1, `r`=1: `d_out` ← mem[`add`], `rd_valid` ← 1.
- `w` and `r` together, same address: read-first. `d_out` gets the pre-write contents, and the array is updated on the same edge.
- `en`=0 or no request: no array change, `rd_valid` ← 0, `d_out` holds.
- Addresses are always in range (full AW decode). There is no out-of-range case.

## Timing
- Read latency 1 cycle: request sampled at edge N, so `d_out`/`rd_valid` are valid after edge N. Back-to-back reads every cycle are supported, and `rd_valid` stays high continuously.
- Write takes effect at the sampling edge. A read of the same address at edge N+1 returns the new data.
- After `rst` deasserts, `busy` stays high for exactly DEPTH rising edges. The first request accepted is on edge DEPTH+1.
- `clr` in IDLE: `busy` rises after that edge and stays high for DEPTH edges in total (the edge that accepted `clr` writes address 0).
- `rst` asserted mid-clear or mid-read: outputs go to reset values immediately, without waiting for a clock edge. The clear then restarts from address 0.
- `busy` and `rd_valid` are never both 1.

## Test plan
- Reset release, WIDTH=16/AW=6/INIT_VALUE=16'hA5A5 -> `busy`=1 for exactly 64 edges. Then reads of addresses 0, 31, 63 each return 16'hA5A5 with `rd_valid` high one cycle after each request.
- IDLE: write 16'h1234 to address 5, then 16'hBEEF to 6; read 5 then 6 back-to-back -> `d_out`=16'h1234 then 16'hBEEF on consecutive cycles, and `rd_valid` stays high both cycles.
- Address 9 holds 16'h0001; same-cycle `w`=`r`=1 to address 9 with `d_in`=16'h00FF -> `d_out`=16'h0001; a read of 9 on the next cycle returns 16'h00FF.
- `en`=0 with `w`=`r`=1 to address 3 -> no `rd_valid`, `d_out` unchanged, and a later read of 3 returns the prior value.
- `clr` pulsed together with a write of 16'h7777 to address 2 -> write dropped, `busy` high 64 cycles. Requests during `busy` are ignored. Afterwards address 2 reads INIT_VALUE.
- `rst` asserted at clear cycle 20 and released -> `busy` high for a full 64 further edges, and `d_out`=0 and `rd_valid`=0 immediately on assertion.

Source files
------------

// File: rtl/ram_sync_clr_if.sv
// rtl/ram_sync_clr_if.sv - request/response bundle for the clearable single-port RAM
interface ram_sync_clr_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 6
);
    logic             en;
    logic             w;
    logic             r;
    logic [AW-1:0]    add;
    logic [WIDTH-1:0] d_in;
    logic             clr;
    logic [WIDTH-1:0] d_out;
    logic             rd_valid;
    logic             busy;

    modport master (
        output en, w, r, add, d_in, clr,
        input  d_out, rd_valid, busy
    );

    modport slave (
        input  en, w, r, add, d_in, clr,
        output d_out, rd_valid, busy
    );
endinterface

// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - single-port synchronous RAM with registered read and hardware clear sequencer
module ram_sync_clr #(
    parameter int               WIDTH      = 16,
    parameter int               AW         = 6,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    ram_sync_clr_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cp_q, cp_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            cp_q       <= '0;
            d_out_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cp_q       <= cp_d;
            d_out_q    <= d_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Read uses the pre-edge array contents, so a same-cycle write to the
    // same address naturally yields read-first behaviour.
    always_comb begin
        state_d    = state_q;
        cp_d       = cp_q;
        d_out_d    = d_out_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = cp_q;
        mem_wdata  = INIT_VALUE;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                if (bus.clr) begin
                    mem_waddr = '0;
                    cp_d      = AW'(1);
                end else begin
                    cp_d = cp_q + AW'(1);
                    if (cp_q == {AW{1'b1}}) begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (bus.clr) begin
                    state_d   = CLEAR;
                    cp_d      = '0;
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                end else if (bus.en) begin
                    if (bus.r) begin
                        d_out_d    = mem_q[bus.add];
                        rd_valid_d = 1'b1;
                    end
                    if (bus.w) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.add;
                        mem_wdata = bus.d_in;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Reset leaves the array alone; only the sequencer clears it afterwards.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_ram_sync_clr.sv
// tb/tb_ram_sync_clr.sv - self-checking bench for ram_sync_clr
module tb_ram_sync_clr;
    localparam int          WIDTH = 16;
    localparam int          AW    = 6;
    localparam int          DEPTH = 64;
    localparam logic [15:0] INIT  = 16'hA5A5;

    logic clk;
    logic rst;
    logic started;
    int   n_checks;
    int   n_pass;

    ram_sync_clr_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    ram_sync_clr #(
        .WIDTH     (WIDTH),
        .AW        (AW),
        .INIT_VALUE(INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Abstract model: clearing is a countdown of remaining busy edges, and the
    // whole array simply takes INIT while a clear is in progress.
    logic [15:0] m_mem [DEPTH];
    int          m_left  = DEPTH;
    logic [15:0] m_dout  = '0;
    logic        m_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  = DEPTH;
            m_dout  = '0;
            m_valid = 1'b0;
        end else if (m_left > 0) begin
            m_valid = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
            m_left = bus.clr ? DEPTH - 1 : m_left - 1;
        end else if (bus.clr) begin
            m_valid = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
            m_left = DEPTH;
        end else begin
            m_valid = bus.en && bus.r;
            if (m_valid) m_dout = m_mem[bus.add];
            if (bus.en && bus.w) m_mem[bus.add] = bus.d_in;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_busy", bus.busy, m_left > 0);
            chk("cyc_rd_valid", bus.rd_valid, m_valid);
            chk("cyc_d_out", bus.d_out, m_dout);
        end
    end

    task automatic set_in(input logic en, input logic w, input logic r,
                          input logic [5:0] a, input logic [15:0] d, input logic c);
        bus.en   = en;
        bus.w    = w;
        bus.r    = r;
        bus.add  = a;
        bus.d_in = d;
        bus.clr  = c;
    endtask

    task automatic cyc(input logic en, input logic w, input logic r,
                       input logic [5:0] a, input logic [15:0] d, input logic c);
        set_in(en, w, r, a, d, c);
        @(posedge clk);
        #2;
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [15:0] exp);
        cyc(1'b1, 1'b0, 1'b1, a, 16'h0000, 1'b0);
        chk({name, "_d_out"}, bus.d_out, exp);
        chk({name, "_rd_valid"}, bus.rd_valid, 1'b1);
    endtask

    // Counts edges until busy falls, optionally hammering requests meanwhile.
    task automatic count_busy(input string name, input bit noise);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (noise)
                set_in(1'b1, 1'b1, 1'b1, 6'($urandom_range(0, 63)), 16'($urandom), 1'b0);
            else
                set_in(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0);
            @(posedge clk);
            #2;
            n++;
        end
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0);
        chk(name, n, DEPTH);
    endtask

    task automatic rst_pulse(input string name, input logic [15:0] d_before);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0);
        chk({name, "_pre_d_out"}, bus.d_out, d_before);
        rst = 1'b1;
        #1;
        chk({name, "_d_out"}, bus.d_out, 16'h0000);
        chk({name, "_rd_valid"}, bus.rd_valid, 1'b0);
        chk({name, "_busy"}, bus.busy, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        count_busy({name, "_busy_edges"}, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        started  = 1'b0;
        rst      = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #2;
        chk("reset_busy", bus.busy, 1'b1);
        chk("reset_rd_valid", bus.rd_valid, 1'b0);
        chk("reset_d_out", bus.d_out, 16'h0000);
        started = 1'b1;
        rst     = 1'b0;
        count_busy("busy_after_reset", 1'b1);

        rd_chk("init_rd0", 6'd0, INIT);
        rd_chk("init_rd31", 6'd31, INIT);
        rd_chk("init_rd63", 6'd63, INIT);

        cyc(1'b1, 1'b1, 1'b0, 6'd5, 16'h1234, 1'b0);
        chk("wr_no_valid", bus.rd_valid, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 6'd6, 16'hBEEF, 1'b0);
        rd_chk("b2b_rd5", 6'd5, 16'h1234);
        rd_chk("b2b_rd6", 6'd6, 16'hBEEF);

        cyc(1'b1, 1'b1, 1'b0, 6'd9, 16'h0001, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 6'd9, 16'h00FF, 1'b0);
        chk("rdfirst_d_out", bus.d_out, 16'h0001);
        chk("rdfirst_rd_valid", bus.rd_valid, 1'b1);
        rd_chk("rdfirst_after", 6'd9, 16'h00FF);

        cyc(1'b0, 1'b1, 1'b1, 6'd3, 16'h5555, 1'b0);
        chk("en0_rd_valid", bus.rd_valid, 1'b0);
        chk("en0_d_out", bus.d_out, 16'h00FF);
        rd_chk("en0_rd3", 6'd3, INIT);

        cyc(1'b1, 1'b1, 1'b0, 6'd63, 16'hCAFE, 1'b0);
        rd_chk("top_addr", 6'd63, 16'hCAFE);

        cyc(1'b1, 1'b1, 1'b0, 6'd2, 16'h7777, 1'b1);
        chk("clr_busy", bus.busy, 1'b1);
        chk("clr_rd_valid", bus.rd_valid, 1'b0);
        count_busy("busy_after_clr", 1'b1);
        rd_chk("clr_rd2", 6'd2, INIT);
        rd_chk("clr_rd5", 6'd5, INIT);
        rd_chk("clr_rd63", 6'd63, INIT);

        cyc(1'b1, 1'b1, 1'b0, 6'd10, 16'h4321, 1'b0);
        rd_chk("pre_rst_rd10", 6'd10, 16'h4321);
        rst_pulse("rst_mid_read", 16'h4321);
        rd_chk("post_rst_rd10", 6'd10, INIT);

        cyc(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b1);
        for (int i = 0; i < 19; i++) cyc(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0);
        rst_pulse("rst_mid_clear", INIT);
        rd_chk("final_rd0", 6'd0, INIT);
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
